zbuf_mem_server: RTL and testbench
==================================

// Module: zbuf_mem_server
// PURPOSE
//  Memory-side responder for the z-buffer cache. Services line-fill requests (mem_rd_*) by streaming
//  LINE_WORDS 32-bit words back over the cache_wr_* handshake, and accepts single-word write-backs
//  (mem_wr_*). Each word holds two packed 16-bit z values. Backed by an internal synchronous-read RAM;
//  replaces the simulation-only memory emulator in synthesizable builds.
// PARAMETERS
//  MEM_AW     12            backing RAM word-address width; the low MEM_AW bits of 19-bit addresses index it
//  LINE_WORDS 8             words per fill burst; power of 2, range 2..32
//  CLEAR_VAL  32'hFFFF_FFFF word written by the reset clear sweep (two far-plane z values)
// PORTS
//  clk            in   1   single clock, rising edge
//  rst            in   1   synchronous, active-high reset
//  mem_rd_addr    in   19  fill request word address; any word within the line
//  mem_rd_en      in   1   fill request level; cache holds it high until cache_wr_done
//  cache_wr_addr  out  19  address of the word being returned
//  cache_wr_data  out  32  returned data word
//  cache_wr_en    out  1   return word valid
//  cache_wr_ack   in   1   cache accepts the current word
//  cache_wr_done  out  1   one-cycle pulse: burst complete
//  mem_wr_addr    in   19  write-back word address
//  mem_wr_data    in   32  write-back data
//  mem_wr_en      in   1   write-back request; held high until mem_wr_ack
//  mem_wr_ack     out  1   one-cycle pulse: write committed
//  init_busy      out  1   reset clear sweep in progress; tied 0 without ZBUF_MEM_CLEAR_EN
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE (CLEAR when ZBUF_MEM_CLEAR_EN is defined); RAM contents untouched.
//  FSM states: IDLE, RD_FETCH, RD_PRESENT, RD_DONE, WR_ACK, CLEAR.
//  - IDLE: mem_wr_en takes priority over mem_rd_en.
//    - Write: RAM written in the same edge; go to WR_ACK.
//    - Read: base = {mem_rd_addr[18:log2(LINE_WORDS)], 0}; latch base; word counter = 0; go to RD_FETCH.
//  - WR_ACK: mem_wr_ack=1 for exactly one cycle; return to IDLE. Write latency: ack 1 cycle after en sampled.
//  - RD_FETCH: issue RAM read of base+cnt (1-cycle read latency); go to RD_PRESENT.
//  - RD_PRESENT: cache_wr_en=1; addr/data are held stable until cache_wr_ack is sampled high.
//    - On ack with cnt==LINE_WORDS-1: go to RD_DONE.
//    - On ack otherwise: cnt++; go to RD_FETCH.
//    - en is deasserted in RD_FETCH, so each word costs at least 2 cycles.
//  - RD_DONE: cache_wr_done=1 for one cycle; en=0; return to IDLE. mem_rd_en is ignored this cycle.
//  - Burst order: ascending from the line base regardless of the requested word. Addresses never cross the line.
//  - Addresses outside 2^MEM_AW alias: upper bits are ignored for RAM indexing but echoed on cache_wr_addr.
//  - mem_wr_en during a burst: stalls; serviced in IDLE after RD_DONE.
//    Same-line write after a fill: the next fill returns the new data.
//  - mem_rd_en dropped mid-burst: the burst still completes (no abort).
//  - ack while cache_wr_en=0: ignored.
//  - rst mid-burst or mid-write: immediate IDLE/CLEAR; outputs 0; no done/ack pulse; partial burst abandoned.
//  - Fill latency: first cache_wr_en 2 cycles after mem_rd_en is sampled in IDLE.
// CONFIGURATION
//  ZBUF_MEM_CLEAR_EN defined:
//  - After reset, state CLEAR writes CLEAR_VAL to every RAM word, address 0..2^MEM_AW-1, one per cycle.
//  - init_busy=1 throughout; rd/wr requests are not sampled until the sweep ends.
//  - Sweep length is exactly 2^MEM_AW cycles, then IDLE.
//  ZBUF_MEM_CLEAR_EN undefined:
//  - No sweep; IDLE immediately after reset; init_busy tied 0; RAM power-up contents are undefined.
// TESTING
//  1. Write mem_wr_addr=0x00010, data=0xDEADBEEF -> mem_wr_ack pulses 1 cycle later.
//     Then fill rd_addr=0x00013 -> words 0x10..0x17 in order; word 0 = 0xDEADBEEF; done pulses once.
//  2. Fill 0x40005 with ack held low 3 cycles on word 2 -> addr/data stable, no skipped or duplicated words,
//     8 ack-qualified words total.
//  3. mem_wr_en(0x40001, 0x0000BEEF) raised mid-fill of line 0x40000 -> ack only after cache_wr_done.
//     Refill of 0x40000 returns 0x0000BEEF at word 1.
//  4. mem_rd_en and mem_wr_en raised in the same IDLE cycle -> write acked first, then the burst starts.
//  5. rst asserted during word 4 of a burst -> all outputs 0 next cycle; no done pulse;
//     a new fill afterwards completes normally.
//  6. With ZBUF_MEM_CLEAR_EN, MEM_AW=4 -> init_busy high 16 cycles after reset.
//     Fill 0x00000 returns 0xFFFFFFFF x8. Without the macro, init_busy stays 0.

Source files
------------

// File: rtl/zbuf_mem_server.sv
// zbuf_mem_server: memory-side responder for the z-buffer cache.
// Streams LINE_WORDS-word line fills over the cache_wr_* handshake and commits single-word
// write-backs into an internal synchronous-read RAM. Each word packs two 16-bit z values.
// Optional build macro ZBUF_MEM_CLEAR_EN: after reset, sweep CLEAR_VAL into every RAM word
// (init_busy high for 2^MEM_AW cycles) before any request is sampled.

module zbuf_mem_server #(
    parameter int unsigned MEM_AW     = 12,
    parameter int unsigned LINE_WORDS = 8,
    parameter logic [31:0] CLEAR_VAL  = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [18:0] mem_rd_addr,
    input  logic        mem_rd_en,
    output logic [18:0] cache_wr_addr,
    output logic [31:0] cache_wr_data,
    output logic        cache_wr_en,
    input  logic        cache_wr_ack,
    output logic        cache_wr_done,
    input  logic [18:0] mem_wr_addr,
    input  logic [31:0] mem_wr_data,
    input  logic        mem_wr_en,
    output logic        mem_wr_ack,
    output logic        init_busy
);

    localparam int unsigned LB    = $clog2(LINE_WORDS);
    localparam int unsigned Depth = 2 ** MEM_AW;

    typedef enum logic [2:0] {
        StIdle,
        StRdFetch,
        StRdPresent,
        StRdDone,
        StWrAck,
        StClear
    } state_e;

    state_e              state_q;
    logic [18-LB:0]      base_q;
    logic [LB-1:0]       cnt_q;
    logic [18:0]         addr_q;
    logic [31:0]         data_q;
    logic                wr_en_q;
    logic                done_q;
    logic                ack_q;
    logic                busy_q;

    logic [31:0]         mem [Depth];
    logic                ram_we;
    logic [MEM_AW-1:0]   ram_waddr;
    logic [31:0]         ram_wdata;
    logic [MEM_AW-1:0]   clr_idx;
    logic [18:0]         rd_word_addr;

    // Line offsets and out-of-range upper bits are intentionally not used for RAM indexing.
    logic unused_addr;
    assign unused_addr = ^{mem_rd_addr, mem_wr_addr};

    assign rd_word_addr = {base_q, cnt_q};

`ifdef ZBUF_MEM_CLEAR_EN
    logic [MEM_AW-1:0] clr_q;
    assign clr_idx = clr_q;

    // Clear-sweep address counter; restarts at every reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_q <= '0;
        end else if (state_q == StClear) begin
            clr_q <= clr_q + 1'b1;
        end
    end
`else
    assign clr_idx = '0;
`endif

    // RAM write port: write-back in IDLE, or the clear sweep; reset never touches contents.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = mem_wr_addr[MEM_AW-1:0];
        ram_wdata = mem_wr_data;
        if (!rst) begin
            case (state_q)
                StIdle:  ram_we = mem_wr_en;
                StClear: begin
                    ram_we    = 1'b1;
                    ram_waddr = clr_idx;
                    ram_wdata = CLEAR_VAL;
                end
                default: ;
            endcase
        end
    end

    // Backing RAM storage, no reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
    end

    // Control FSM with registered outputs; the RAM read register lives here so it resets to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef ZBUF_MEM_CLEAR_EN
            state_q <= StClear;
            busy_q  <= 1'b1;
`else
            state_q <= StIdle;
            busy_q  <= 1'b0;
`endif
            base_q  <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    // Write-back wins over a fill request seen in the same cycle.
                    if (mem_wr_en) begin
                        ack_q   <= 1'b1;
                        state_q <= StWrAck;
                    end else if (mem_rd_en) begin
                        base_q  <= mem_rd_addr[18:LB];
                        cnt_q   <= '0;
                        state_q <= StRdFetch;
                    end
                end
                StWrAck: begin
                    ack_q   <= 1'b0;
                    state_q <= StIdle;
                end
                StRdFetch: begin
                    data_q  <= mem[rd_word_addr[MEM_AW-1:0]];
                    addr_q  <= rd_word_addr;
                    wr_en_q <= 1'b1;
                    state_q <= StRdPresent;
                end
                StRdPresent: begin
                    // Hold addr/data until the cache accepts the word.
                    if (cache_wr_ack) begin
                        wr_en_q <= 1'b0;
                        if (cnt_q == LB'(LINE_WORDS - 1)) begin
                            done_q  <= 1'b1;
                            state_q <= StRdDone;
                        end else begin
                            cnt_q   <= cnt_q + 1'b1;
                            state_q <= StRdFetch;
                        end
                    end
                end
                StRdDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                StClear: begin
`ifdef ZBUF_MEM_CLEAR_EN
                    if (clr_q == MEM_AW'(Depth - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
`else
                    state_q <= StIdle;
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cache_wr_addr = addr_q;
    assign cache_wr_data = data_q;
    assign cache_wr_en   = wr_en_q;
    assign cache_wr_done = done_q;
    assign mem_wr_ack    = ack_q;
    assign init_busy     = busy_q;

endmodule

// File: tb/tb_zbuf_mem_server.sv
// Directed self-checking bench for zbuf_mem_server (default parameters).
// Build with ZBUF_MEM_CLEAR_EN defined to exercise the reset clear sweep.

module tb_zbuf_mem_server;

    logic        clk = 1'b0;
    logic        rst;
    logic [18:0] mem_rd_addr;
    logic        mem_rd_en;
    logic [18:0] cache_wr_addr;
    logic [31:0] cache_wr_data;
    logic        cache_wr_en;
    logic        cache_wr_ack;
    logic        cache_wr_done;
    logic [18:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr_en;
    logic        mem_wr_ack;
    logic        init_busy;

    int checks = 0;
    int errors = 0;

    // Results of the most recent fill
    logic [18:0] got_addr [8];
    logic [31:0] got_data [8];
    int n_words, done_cnt, first_lat, ack_cyc, done_cyc, stable_err, aborted;
    logic out_or;
    int lat, busy_n;

`ifdef ZBUF_MEM_CLEAR_EN
    localparam logic EXP_BUSY = 1'b1;
`else
    localparam logic EXP_BUSY = 1'b0;
`endif

    zbuf_mem_server dut (
        .clk           (clk),
        .rst           (rst),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_en     (mem_rd_en),
        .cache_wr_addr (cache_wr_addr),
        .cache_wr_data (cache_wr_data),
        .cache_wr_en   (cache_wr_en),
        .cache_wr_ack  (cache_wr_ack),
        .cache_wr_done (cache_wr_done),
        .mem_wr_addr   (mem_wr_addr),
        .mem_wr_data   (mem_wr_data),
        .mem_wr_en     (mem_wr_en),
        .mem_wr_ack    (mem_wr_ack),
        .init_busy     (init_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Single write-back; lat = negedges from raising en until mem_wr_ack is seen.
    task automatic do_write(input logic [18:0] a, input logic [31:0] d, output int l);
        @(negedge clk);
        mem_wr_addr = a;
        mem_wr_data = d;
        mem_wr_en   = 1'b1;
        l = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_wr_ack) begin
                l = c;
                break;
            end
        end
        mem_wr_en = 1'b0;
    endtask

    // Cache-side fill agent. stall_word/stall_n: hold ack low on that word; wr_word: raise the
    // pre-loaded write-back when that word appears; wr_now: raise write with the request;
    // rst_word: pulse reset when that word appears; ack_idle: drive ack high while en is low.
    task automatic run_fill(input logic [18:0] a, input int stall_word, input int stall_n,
                            input int wr_word, input logic wr_now, input int rst_word,
                            input logic ack_idle);
        int stall_left;
        logic wr_armed;
        logic finished;
        logic [18:0] hold_a;
        logic [31:0] hold_d;
        n_words = 0; done_cnt = 0; first_lat = -1; ack_cyc = -1; done_cyc = -1;
        stable_err = 0; aborted = 0; out_or = 1'b1;
        stall_left = stall_n; wr_armed = (wr_word >= 0); finished = 1'b0;
        hold_a = '0; hold_d = '0;
        for (int i = 0; i < 8; i++) begin
            got_addr[i] = 'x;
            got_data[i] = 'x;
        end
        @(negedge clk);
        mem_rd_addr = a;
        mem_rd_en   = 1'b1;
        if (wr_now) mem_wr_en = 1'b1;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (mem_wr_ack) begin
                if (ack_cyc < 0) ack_cyc = cyc;
                mem_wr_en = 1'b0;
            end
            if (cache_wr_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                mem_rd_en = 1'b0;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2 && !mem_wr_en) begin
                finished = 1'b1;
                break;
            end
            if (cache_wr_en) begin
                if (first_lat < 0) first_lat = cyc;
                if (n_words == rst_word) begin
                    rst = 1'b1;
                    cache_wr_ack = 1'b0;
                    @(negedge clk);
                    out_or = |{cache_wr_en, cache_wr_done, mem_wr_ack, cache_wr_addr, cache_wr_data};
                    rst = 1'b0;
                    mem_rd_en = 1'b0;
                    aborted = 1;
                    finished = 1'b1;
                    break;
                end
                if (wr_armed && n_words == wr_word) begin
                    mem_wr_en = 1'b1;
                    wr_armed = 1'b0;
                end
                if (n_words == stall_word && stall_n > 0) begin
                    if (stall_left == stall_n) begin
                        hold_a = cache_wr_addr;
                        hold_d = cache_wr_data;
                    end else if (cache_wr_addr !== hold_a || cache_wr_data !== hold_d) begin
                        stable_err++;
                    end
                end
                if (n_words == stall_word && stall_left > 0) begin
                    stall_left--;
                    cache_wr_ack = 1'b0;
                end else begin
                    if (n_words < 8) begin
                        got_addr[n_words] = cache_wr_addr;
                        got_data[n_words] = cache_wr_data;
                    end
                    n_words++;
                    cache_wr_ack = 1'b1;
                end
            end else begin
                cache_wr_ack = ack_idle;
            end
        end
        cache_wr_ack = 1'b0;
        mem_rd_en    = 1'b0;
        chk("fill terminated", 32'(finished), 32'd1);
    endtask

    initial begin
        rst = 1'b1; mem_rd_addr = '0; mem_rd_en = 1'b0; cache_wr_ack = 1'b0;
        mem_wr_addr = '0; mem_wr_data = '0; mem_wr_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset outputs", 32'(|{cache_wr_en, cache_wr_done, mem_wr_ack,
                                   cache_wr_addr, cache_wr_data}), 32'd0);
        chk("reset init_busy", 32'(init_busy), 32'(EXP_BUSY));
        rst = 1'b0;

        // Clear sweep length (0 without the macro)
        busy_n = 0;
        for (int c = 0; c < 5000; c++) begin
            if (!init_busy) break;
            busy_n++;
            @(negedge clk);
        end
`ifdef ZBUF_MEM_CLEAR_EN
        chk("sweep cycles", 32'(busy_n), 32'd4096);
        run_fill(19'h00000, -1, 0, -1, 1'b0, -1, 1'b0);
        for (int i = 0; i < 8; i++) chk("cleared word", got_data[i], 32'hFFFF_FFFF);
`else
        chk("sweep cycles", 32'(busy_n), 32'd0);
`endif

        // Preload line 0x40000
        for (int i = 0; i < 8; i++) begin
            do_write(19'h40000 + 19'(i), 32'hA5A5_0000 + 32'(i), lat);
            chk("preload ack latency", 32'(lat), 32'd1);
        end

        // 1: write then fill of the containing line from a mid-line address
        do_write(19'h00010, 32'hDEAD_BEEF, lat);
        chk("t1 ack latency", 32'(lat), 32'd1);
        @(negedge clk);
        chk("t1 ack one cycle", 32'(mem_wr_ack), 32'd0);
        run_fill(19'h00013, -1, 0, -1, 1'b0, -1, 1'b0);
        chk("t1 fill latency", 32'(first_lat), 32'd2);
        chk("t1 words", 32'(n_words), 32'd8);
        chk("t1 done pulses", 32'(done_cnt), 32'd1);
        for (int i = 0; i < 8; i++) chk("t1 addr", 32'(got_addr[i]), 32'h10 + 32'(i));
        chk("t1 word0 data", got_data[0], 32'hDEAD_BEEF);

        // Aliasing: upper bits ignored for indexing, echoed on the address
        run_fill(19'h41013, -1, 0, -1, 1'b0, -1, 1'b0);
        chk("alias addr0", 32'(got_addr[0]), 32'h41010);
        chk("alias addr7", 32'(got_addr[7]), 32'h41017);
        chk("alias data0", got_data[0], 32'hDEAD_BEEF);

        // 2: stall 3 cycles on word 2, with stray acks while en is low
        run_fill(19'h40005, 2, 3, -1, 1'b0, -1, 1'b1);
        chk("t2 words", 32'(n_words), 32'd8);
        chk("t2 stable", 32'(stable_err), 32'd0);
        chk("t2 done pulses", 32'(done_cnt), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("t2 addr", 32'(got_addr[i]), 32'h40000 + 32'(i));
            chk("t2 data", got_data[i], 32'hA5A5_0000 + 32'(i));
        end

        // 3: write-back raised mid-fill is deferred until after done
        mem_wr_addr = 19'h40001; mem_wr_data = 32'h0000_BEEF;
        run_fill(19'h40000, -1, 0, 3, 1'b0, -1, 1'b0);
        chk("t3 done pulses", 32'(done_cnt), 32'd1);
        chk("t3 ack after done", 32'(ack_cyc - done_cyc), 32'd2);
        chk("t3 old data word1", got_data[1], 32'hA5A5_0001);
        run_fill(19'h40000, -1, 0, -1, 1'b0, -1, 1'b0);
        chk("t3 refill word1", got_data[1], 32'h0000_BEEF);
        chk("t3 refill word2", got_data[2], 32'hA5A5_0002);

        // 4: simultaneous read and write requests, write first
        mem_wr_addr = 19'h40002; mem_wr_data = 32'h1234_5678;
        run_fill(19'h40000, -1, 0, -1, 1'b1, -1, 1'b0);
        chk("t4 ack cycle", 32'(ack_cyc), 32'd1);
        chk("t4 fill latency", 32'(first_lat), 32'd4);
        chk("t4 words", 32'(n_words), 32'd8);
        chk("t4 word2 data", got_data[2], 32'h1234_5678);

        // 5: reset during word 4, then a normal fill
        run_fill(19'h40000, -1, 0, -1, 1'b0, 4, 1'b0);
        chk("t5 aborted", 32'(aborted), 32'd1);
        chk("t5 outputs zero", 32'(out_or), 32'd0);
        chk("t5 no done", 32'(done_cnt), 32'd0);
        for (int c = 0; c < 5000; c++) begin
            if (!init_busy) break;
            @(negedge clk);
        end
        chk("t5 sweep ended", 32'(init_busy), 32'd0);
        run_fill(19'h40003, -1, 0, -1, 1'b0, -1, 1'b0);
        chk("t5 words", 32'(n_words), 32'd8);
        chk("t5 done pulses", 32'(done_cnt), 32'd1);
        chk("t5 addr0", 32'(got_addr[0]), 32'h40000);
        chk("t5 addr7", 32'(got_addr[7]), 32'h40007);
`ifdef ZBUF_MEM_CLEAR_EN
        chk("t5 word1 cleared", got_data[1], 32'hFFFF_FFFF);
`else
        chk("t5 word1 kept", got_data[1], 32'h0000_BEEF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
